// File: rtl/frog_input_ctrl.sv
// Keyboard keycode to one-cycle frog move pulses: edge detect, one-deep pending buffer, move counter.
// Optional hold-to-repeat state machine compiled in with `define FROG_AUTOREPEAT_EN.
module frog_input_ctrl #(
  parameter logic [7:0] REPEAT_DELAY  = 8'd30,
  parameter logic [7:0] REPEAT_PERIOD = 8'd10
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic        frog_busy,
  output logic        up,
  output logic        down,
  output logic        left,
  output logic        right,
  output logic [1:0]  cur_dir,
  output logic        move_pending,
  output logic [15:0] move_count
);

  logic       key_v;
  logic [1:0] key_dir;
  logic       prev_v;
  logic [1:0] prev_dir;
  logic       press;
  logic       tick;
  logic       req;
  logic [1:0] pend_dir;
  logic       cand_v;
  logic [1:0] cand_dir;

  always_comb begin
    key_v   = 1'b1;
    key_dir = 2'd0;
    case (keycode)
      8'h52, 8'h1A: key_dir = 2'd0;
      8'h51, 8'h16: key_dir = 2'd1;
      8'h50, 8'h04: key_dir = 2'd2;
      8'h4F, 8'h07: key_dir = 2'd3;
      default:      key_v   = 1'b0;
    endcase
  end

  assign press = key_v && (!prev_v || (key_dir != prev_dir));

`ifdef FROG_AUTOREPEAT_EN
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} rpt_state_t;

  rpt_state_t state;
  logic [7:0] cnt;

  // A fresh press restarts the delay, so it never doubles as a repeat tick.
  assign tick = key_v && !press &&
                (((state == S_DELAY)  && (cnt == REPEAT_DELAY  - 8'd1)) ||
                 ((state == S_REPEAT) && (cnt == REPEAT_PERIOD - 8'd1)));

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (!key_v) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (press) begin
      state <= S_DELAY;
      cnt   <= '0;
    end else begin
      case (state)
        S_DELAY: begin
          if (cnt == REPEAT_DELAY - 8'd1) begin
            state <= S_REPEAT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_REPEAT: begin
          if (cnt == REPEAT_PERIOD - 8'd1) cnt <= '0;
          else                             cnt <= cnt + 8'd1;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
`else
  // Parameters are kept for interface compatibility only; folded into a constant-zero tick.
  localparam bit PARAMS_OK = (REPEAT_DELAY != 8'd0) && (REPEAT_PERIOD != 8'd0);
  assign tick = PARAMS_OK & 1'b0;
`endif

  // A repeat of the direction already waiting in the buffer adds nothing.
  assign req      = press || (tick && !(move_pending && (pend_dir == key_dir)));
  assign cand_v   = req || move_pending;
  assign cand_dir = req ? key_dir : pend_dir;

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      up           <= 1'b0;
      down         <= 1'b0;
      left         <= 1'b0;
      right        <= 1'b0;
      cur_dir      <= '0;
      move_pending <= 1'b0;
      pend_dir     <= '0;
      move_count   <= '0;
      prev_v       <= 1'b0;
      prev_dir     <= '0;
    end else begin
      prev_v   <= key_v;
      prev_dir <= key_dir;
      up       <= 1'b0;
      down     <= 1'b0;
      left     <= 1'b0;
      right    <= 1'b0;
      if (cand_v && !frog_busy) begin
        case (cand_dir)
          2'd0:    up    <= 1'b1;
          2'd1:    down  <= 1'b1;
          2'd2:    left  <= 1'b1;
          default: right <= 1'b1;
        endcase
        cur_dir      <= cand_dir;
        move_count   <= move_count + 16'd1;
        move_pending <= 1'b0;
      end else if (cand_v) begin
        pend_dir     <= cand_dir;
        move_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frog_input_ctrl.sv
// Self-checking bench for frog_input_ctrl: directed vector table, repeat/wrap sequences,
// and randomized stimulus against a frame-age based reference model.
module tb_frog_input_ctrl;

  localparam logic [7:0] DLY = 8'd4;
  localparam logic [7:0] PER = 8'd2;

  logic        frame_clk = 1'b0;
  logic        Reset     = 1'b1;
  logic [7:0]  keycode   = 8'h00;
  logic        frog_busy = 1'b0;
  logic        up, down, left, right;
  logic [1:0]  cur_dir;
  logic        move_pending;
  logic [15:0] move_count;

  frog_input_ctrl #(.REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycode     (keycode),
    .frog_busy   (frog_busy),
    .up          (up),
    .down        (down),
    .left        (left),
    .right       (right),
    .cur_dir     (cur_dir),
    .move_pending(move_pending),
    .move_count  (move_count)
  );

  always #5 frame_clk = ~frame_clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b1;

  // Reference model: key age in frames since the press, plus the one-deep buffer.
  bit          m_pv;
  logic [1:0]  m_pd;
  int          m_age;
  bit          m_pendv;
  logic [1:0]  m_pendd;
  logic [3:0]  m_pulse;
  logic [1:0]  m_dir;
  logic [15:0] m_cnt;

  function automatic void decode(input logic [7:0] k, output bit v, output logic [1:0] d);
    v = 1'b1;
    d = 2'd0;
    case (k)
      8'h52, 8'h1A: d = 2'd0;
      8'h51, 8'h16: d = 2'd1;
      8'h50, 8'h04: d = 2'd2;
      8'h4F, 8'h07: d = 2'd3;
      default:      v = 1'b0;
    endcase
  endfunction

  task automatic model_edge(input logic rst, input logic [7:0] k, input logic busy);
    bit v, press, tick, req, cv;
    logic [1:0] d, cd;
    decode(k, v, d);
    if (rst) begin
      m_pv = 0; m_pd = 0; m_age = 0; m_pendv = 0; m_pendd = 0;
      m_pulse = 0; m_dir = 0; m_cnt = 0;
      return;
    end
    press = v && (!m_pv || d != m_pd);
    if (press)  m_age = 0;
    else if (v) m_age++;
    tick = 1'b0;
`ifdef FROG_AUTOREPEAT_EN
    tick = v && !press && (m_age >= int'(DLY)) && (((m_age - int'(DLY)) % int'(PER)) == 0);
`endif
    req = press || (tick && !(m_pendv && m_pendd == d));
    cv  = req || m_pendv;
    cd  = req ? d : m_pendd;
    m_pulse = 4'b0000;
    if (cv && !busy) begin
      m_pulse = 4'b1000 >> cd;
      m_dir   = cd;
      m_cnt   = m_cnt + 16'd1;
      m_pendv = 1'b0;
    end else if (cv) begin
      m_pendd = cd;
      m_pendv = 1'b1;
    end
    m_pv = v;
    m_pd = d;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic [7:0] k, input logic busy);
    Reset     = rst;
    keycode   = k;
    frog_busy = busy;
    @(posedge frame_clk);
    model_edge(rst, k, busy);
    #1;
    if (chk_en) begin
      check("model_pulses",  {28'd0, up, down, left, right}, {28'd0, m_pulse});
      check("model_cur_dir", {30'd0, cur_dir}, {30'd0, m_dir});
      check("model_pending", {31'd0, move_pending}, {31'd0, m_pendv});
      check("model_count",   {16'd0, move_count}, {16'd0, m_cnt});
    end
  endtask

  typedef struct {
    logic        rst;
    logic [7:0]  key;
    logic        busy;
    logic [3:0]  pulse;
    logic [1:0]  dir;
    logic        pend;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[27];

  initial begin
    logic [15:0] mask;
    logic [15:0] exp_mask;
    logic [7:0]  keys[11];
    logic [7:0]  k;
    logic        b, r;

    tbl[0]  = '{1'b1, 8'h00, 1'b0, 4'b0000, 2'd0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 8'h1A, 1'b0, 4'b1000, 2'd0, 1'b0, 16'd1};
    tbl[2]  = '{1'b0, 8'h1A, 1'b0, 4'b0000, 2'd0, 1'b0, 16'd1};
    tbl[3]  = '{1'b0, 8'h1A, 1'b0, 4'b0000, 2'd0, 1'b0, 16'd1};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 4'b0000, 2'd0, 1'b0, 16'd1};
    tbl[5]  = '{1'b0, 8'h50, 1'b1, 4'b0000, 2'd0, 1'b1, 16'd1};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 4'b0000, 2'd0, 1'b1, 16'd1};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 4'b0000, 2'd0, 1'b1, 16'd1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 4'b0000, 2'd0, 1'b1, 16'd1};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 4'b0000, 2'd0, 1'b1, 16'd1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 4'b0010, 2'd2, 1'b0, 16'd2};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 4'b0000, 2'd2, 1'b0, 16'd2};
    tbl[12] = '{1'b0, 8'h52, 1'b1, 4'b0000, 2'd2, 1'b1, 16'd2};
    tbl[13] = '{1'b0, 8'h4F, 1'b1, 4'b0000, 2'd2, 1'b1, 16'd2};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 4'b0001, 2'd3, 1'b0, 16'd3};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 4'b0000, 2'd3, 1'b0, 16'd3};
    tbl[16] = '{1'b0, 8'h51, 1'b1, 4'b0000, 2'd3, 1'b1, 16'd3};
    tbl[17] = '{1'b1, 8'h51, 1'b1, 4'b0000, 2'd0, 1'b0, 16'd0};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 4'b0000, 2'd0, 1'b0, 16'd0};
    tbl[19] = '{1'b1, 8'h07, 1'b0, 4'b0000, 2'd0, 1'b0, 16'd0};
    tbl[20] = '{1'b0, 8'h07, 1'b0, 4'b0001, 2'd3, 1'b0, 16'd1};
    tbl[21] = '{1'b0, 8'h00, 1'b0, 4'b0000, 2'd3, 1'b0, 16'd1};
    tbl[22] = '{1'b0, 8'h04, 1'b1, 4'b0000, 2'd3, 1'b1, 16'd1};
    tbl[23] = '{1'b0, 8'h16, 1'b0, 4'b0100, 2'd1, 1'b0, 16'd2};
    tbl[24] = '{1'b0, 8'h00, 1'b0, 4'b0000, 2'd1, 1'b0, 16'd2};
    tbl[25] = '{1'b0, 8'h29, 1'b0, 4'b0000, 2'd1, 1'b0, 16'd2};
    tbl[26] = '{1'b0, 8'h00, 1'b0, 4'b0000, 2'd1, 1'b0, 16'd2};

    for (int i = 0; i < 27; i++) begin
      step(tbl[i].rst, tbl[i].key, tbl[i].busy);
      check($sformatf("vec%0d_pulses", i), {28'd0, up, down, left, right}, {28'd0, tbl[i].pulse});
      check($sformatf("vec%0d_dir", i), {30'd0, cur_dir}, {30'd0, tbl[i].dir});
      check($sformatf("vec%0d_pend", i), {31'd0, move_pending}, {31'd0, tbl[i].pend});
      check($sformatf("vec%0d_count", i), {16'd0, move_count}, {16'd0, tbl[i].cnt});
    end

    // Hold S (down) for 10 frames; record which offsets carry a down pulse.
    step(1'b1, 8'h00, 1'b0);
    mask = '0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h16, 1'b0);
      if (down) mask[i + 1] = 1'b1;
    end
`ifdef FROG_AUTOREPEAT_EN
    exp_mask = 16'h02A2;
`else
    exp_mask = 16'h0002;
`endif
    check("repeat_offsets", {16'd0, mask}, {16'd0, exp_mask});
    step(1'b0, 8'h00, 1'b0);

    // Counter wrap: alternate up/down so every frame is a press.
    step(1'b1, 8'h00, 1'b0);
    chk_en = 1'b0;
    for (int i = 0; i < 65535; i++) step(1'b0, (i % 2 == 1) ? 8'h51 : 8'h52, 1'b0);
    chk_en = 1'b1;
    check("count_ffff", {16'd0, move_count}, 32'h0000_FFFF);
    step(1'b0, 8'h51, 1'b0);
    check("count_wrap", {16'd0, move_count}, 32'd0);
    check("wrap_pulse", {28'd0, up, down, left, right}, 32'h4);

    // Reset while a move is buffered.
    step(1'b0, 8'h52, 1'b1);
    check("pend_before_reset", {31'd0, move_pending}, 32'd1);
    step(1'b1, 8'h52, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    check("no_pulse_after_reset", {28'd0, up, down, left, right}, 32'd0);

    // Randomized stimulus with keys held for several frames on average.
    keys = '{8'h00, 8'h52, 8'h1A, 8'h51, 8'h16, 8'h50, 8'h04, 8'h4F, 8'h07, 8'h29, 8'hFF};
    k = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) k = keys[$urandom_range(10)];
      b = ($urandom_range(2) == 0);
      r = ($urandom_range(99) == 0);
      step(r, k, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frog_input_ctrl.md
# frog_input_ctrl

- Converts the keyboard keycode into the one-cycle `up`/`down`/`left`/`right` move pulses that the frog block consumes.
- Sits between the USB keyboard interface and the frog, and runs on `frame_clk`.
- Provides press edge detection, a one-deep pending-move buffer held off by `frog_busy`, an optional hold-to-repeat state machine, and a move counter.

## Interface
- `REPEAT_DELAY`, 8'd30: frames a key must be held before the first auto-repeat.
- `REPEAT_PERIOD`, 8'd10: frames between subsequent auto-repeats.
- `frame_clk`  in  1  sole clock, one edge per frame.
- `Reset`  in  1  synchronous, active-high reset.
- `keycode`  in  8  current USB HID keycode; 8'h00 means no key. Stable across the edge.
- `frog_busy`  in  1  frog hop in progress; move pulses are withheld while high.
- `up`, `down`, `left`, `right`  out  1 each  registered move pulses, at most one high per cycle.
- `cur_dir`  out  2  last issued direction: 0 up, 1 down, 2 left, 3 right.
- `move_pending`  out  1  pending-move buffer valid.
- `move_count`  out  16  number of pulses issued, wraps 16'hFFFF→0.

## Operation
- **Decode** (combinational), giving `key_v`/`key_dir`:
  - Up: 8'h52 or 8'h1A (W).
  - Down: 8'h51 or 8'h16 (S).
  - Left: 8'h50 or 8'h04 (A).
  - Right: 8'h4F or 8'h07 (D).
  - All other codes: `key_v`=0.
- **Press detection**: `prev_v`/`prev_dir` are registered every edge.
  - A press is `key_v && (!prev_v || key_dir != prev_dir)`.
  - A direction change while a key is held counts as a press.
- **Request**: `req` = press, or a repeat tick from the FSM. The request direction is `key_dir`.
- **Issue and buffer**, evaluated at each edge:
  - Candidate is `req ? key_dir : pend_dir`; it is valid if `req || pend_v`. The latest request wins and a pending move is overwritten.
  - Candidate valid and `!frog_busy`: assert the matching pulse for the next cycle, set `cur_dir`, increment `move_count`, clear `pend_v`.
  - Candidate valid and `frog_busy`: store the candidate in `pend_dir`, set `pend_v`, no pulse.
  - Otherwise: all pulses 0.
- **Pending retention**: a pending move survives key release and is issued once `frog_busy` falls.
- **Repeat FSM** with 8-bit counter `cnt`:
  - IDLE: on press → DELAY, `cnt`=0.
  - DELAY: `cnt`++ each cycle. At `cnt==REPEAT_DELAY-1` → REPEAT, `cnt`=0, repeat tick.
  - REPEAT: `cnt`++. At `cnt==REPEAT_PERIOD-1` → `cnt`=0, repeat tick.
  - From any state, `!key_v` → IDLE. A press in DELAY or REPEAT → DELAY, `cnt`=0.
- **Duplicate suppression**: a repeat tick while `pend_v` is set with the same direction is dropped. Moves never accumulate beyond one.

## Timing
- Reset values:
  - All pulses 0, `cur_dir`=2'd0, `move_pending`=0, `move_count`=0.
  - FSM IDLE, `cnt`=0, `prev_v`=0.
- Latency: a key sampled at edge k with `frog_busy`=0 gives a pulse high for exactly the cycle following edge k.
- Pending drain: the pulse follows the first edge at which `frog_busy`=0.
- Simultaneous press and pending: the press direction is issued or buffered; the older pending move is discarded.
- Key held through reset: the first edge with `Reset`=0 detects a press, since `prev_v` was cleared.
- Reset mid-operation: abandons the pending move and the FSM state with no pulse.
- `REPEAT_DELAY` and `REPEAT_PERIOD` must be ≥1. A value of 1 ticks every cycle.

## Configuration
- `FROG_AUTOREPEAT_EN` defined: the repeat FSM is compiled in as described.
- `FROG_AUTOREPEAT_EN` undefined: the FSM and `cnt` are removed and the repeat tick is tied 0.
  - Exactly one move per press or direction change.
  - The parameters are accepted but unused.

## Test plan
- Reset, then `keycode`=8'h1A for 3 cycles with `frog_busy`=0 → `up` high exactly 1 cycle, the cycle after the first sampled edge. `move_count`=1, `cur_dir`=0.
- `frog_busy`=1, tap 8'h50 for 1 cycle, hold busy 5 cycles, then drop busy → `move_pending`=1 for 5 cycles. Then `left` pulses once, `move_pending`=0, `cur_dir`=2.
- `frog_busy`=1, `keycode` 8'h52 then 8'h4F on consecutive edges, then busy=0 → only `right` pulses; `move_count` +1.
- With `FROG_AUTOREPEAT_EN`, `REPEAT_DELAY`=4, `REPEAT_PERIOD`=2, hold 8'h16 for 10 cycles → `down` pulses at cycle offsets 1, 5, 7, 9. Without the macro → a single pulse at offset 1.
- Preload `move_count`=16'hFFFF via 65535 taps, issue one more → wraps to 0. Assert `Reset` while a move is pending with busy=1 → no pulse, all outputs reset.
